// File: rtl/ppu_scan_timing.sv
// ----------------------------------------------------------------------------
// ppu_scan_timing
//   NTSC 2C02 dot/scanline timing controller. Steps the dot and scanline
//   counters on every dot clock-enable. It decodes the visible-pixel strobe
//   and coordinates for the pixel pipeline. It also owns the vblank status flag
//   and the NMI request derived from that flag.
//
// Optional feature macro: ODD_FRAME_SKIP_EN
//   Defined   : on odd frames with rendering enabled, the last dot of the
//               pre-render line is skipped (the frame is one dot shorter).
//   Undefined : every frame is DOTS*LINES dots and i_render_en is ignored.
//
// Ports
//   clk          in   1  clock
//   rst          in   1  synchronous, active-high reset
//   i_ce         in   1  dot clock-enable; counters advance only when high
//   i_render_en  in   1  background|sprite rendering enabled
//   i_nmi_en     in   1  NMI-on-vblank enable
//   i_vblank_clr in   1  status-read pulse, clears vblank (ignores i_ce)
//   o_dot        out  9  current dot (0..DOTS-1)
//   o_scanline   out  9  current scanline (0..LINES-1)
//   o_pixel_en   out  1  current dot is a visible pixel
//   o_pixel_x    out  8  dot-1 while o_pixel_en, else 0
//   o_pixel_y    out  8  scanline while o_pixel_en, else 0
//   o_frame      out  1  vblank status flag
//   o_nmi        out  1  registered level NMI request (frame & nmi_en)
//   o_frame_odd  out  1  odd-frame parity
// ----------------------------------------------------------------------------
module ppu_scan_timing #(
  parameter int DOTS     = 341,
  parameter int LINES    = 262,
  parameter int VIS_W    = 256,
  parameter int VIS_H    = 240,
  parameter int VBL_LINE = 241,
  parameter int PRE_LINE = 261
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ce,
  input  logic       i_render_en,
  input  logic       i_nmi_en,
  input  logic       i_vblank_clr,
  output logic [8:0] o_dot,
  output logic [8:0] o_scanline,
  output logic       o_pixel_en,
  output logic [7:0] o_pixel_x,
  output logic [7:0] o_pixel_y,
  output logic       o_frame,
  output logic       o_nmi,
  output logic       o_frame_odd
);

  localparam logic [8:0] LP_DOT_LAST  = 9'(DOTS - 1);
  localparam logic [8:0] LP_LINE_LAST = 9'(LINES - 1);
  localparam logic [8:0] LP_VIS_W     = 9'(VIS_W);
  localparam logic [8:0] LP_VIS_H     = 9'(VIS_H);
  localparam logic [8:0] LP_VBL_LINE  = 9'(VBL_LINE);
  localparam logic [8:0] LP_PRE_LINE  = 9'(PRE_LINE);

  logic [8:0] r_dot;
  logic [8:0] r_scanline;
  logic       r_frame;
  logic       r_nmi;
  logic       r_frame_odd;

  logic       w_dot_last;
  logic       w_frame_wrap;
  logic       w_skip;
  logic       w_vbl_set;
  logic       w_vbl_clr;
  logic       w_frame_next;

`ifdef ODD_FRAME_SKIP_EN
  localparam logic [8:0] LP_DOT_SKIP = 9'(DOTS - 2);

  // The odd-frame short cut: jumping straight from (PRE_LINE, DOTS-2) to
  // (0,0) drops the final pre-render dot.
  assign w_skip = (r_scanline == LP_PRE_LINE) && (r_dot == LP_DOT_SKIP) &&
                  r_frame_odd && i_render_en;
`else
  logic w_unused_render_en;

  assign w_skip             = 1'b0;
  assign w_unused_render_en = i_render_en;
`endif

  // Wrap detection. A skipped dot ends the frame just like the natural last dot.
  always_comb begin
    w_dot_last   = (r_dot == LP_DOT_LAST);
    w_frame_wrap = w_skip || (w_dot_last && (r_scanline == LP_LINE_LAST));
  end

  // Vblank flag next state. A status read wins over the set event, so a read
  // landing on the set dot suppresses the flag (and NMI) for the whole frame.
  always_comb begin
    w_vbl_set = i_ce && (r_scanline == LP_VBL_LINE) && (r_dot == 9'd1);
    w_vbl_clr = i_vblank_clr || (i_ce && (r_scanline == LP_PRE_LINE) && (r_dot == 9'd1));
    w_frame_next = r_frame;
    if (w_vbl_clr) begin
      w_frame_next = 1'b0;
    end else if (w_vbl_set) begin
      w_frame_next = 1'b1;
    end
  end

  // Dot/scanline counters and frame parity, all gated by the dot enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dot       <= 9'd0;
      r_scanline  <= 9'd0;
      r_frame_odd <= 1'b0;
    end else if (i_ce) begin
      if (w_frame_wrap) begin
        r_dot       <= 9'd0;
        r_scanline  <= 9'd0;
        r_frame_odd <= ~r_frame_odd;
      end else if (w_dot_last) begin
        r_dot      <= 9'd0;
        r_scanline <= r_scanline + 9'd1;
      end else begin
        r_dot <= r_dot + 9'd1;
      end
    end
  end

  // Vblank flag and NMI update every clock, because a status read must be
  // honoured even between dot enables. NMI tracks the flag's next value so
  // both change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame <= 1'b0;
      r_nmi   <= 1'b0;
    end else begin
      r_frame <= w_frame_next;
      r_nmi   <= w_frame_next & i_nmi_en;
    end
  end

  // Visible-window decode straight from the counters (no added latency).
  // Inside the window the dot is 1..256, so the low byte minus one is exact
  // (dot 256 wraps its low byte 0 to 255).
  always_comb begin
    o_pixel_en = (r_scanline < LP_VIS_H) && (r_dot >= 9'd1) && (r_dot <= LP_VIS_W);
    o_pixel_x  = 8'd0;
    o_pixel_y  = 8'd0;
    if (o_pixel_en) begin
      o_pixel_x = r_dot[7:0] - 8'd1;
      o_pixel_y = r_scanline[7:0];
    end
  end

  assign o_dot       = r_dot;
  assign o_scanline  = r_scanline;
  assign o_frame     = r_frame;
  assign o_nmi       = r_nmi;
  assign o_frame_odd = r_frame_odd;

endmodule
